// File: rtl/pw_pkg.sv
// Shared types and helpers for the password key-entry path.
package pw_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ENTRY    = 2'd1,
        UNLOCKED = 2'd2,
        LOCKOUT  = 2'd3
    } pw_state_t;

    localparam int NUM_KEYS = 4;

    localparam logic [1:0] KEY_A = 2'd0;
    localparam logic [1:0] KEY_B = 2'd1;
    localparam logic [1:0] KEY_C = 2'd2;
    localparam logic [1:0] KEY_D = 2'd3;

    // Digit n of a packed password, two bits per digit, digit 0 at the LSBs.
    function automatic logic [1:0] pw_digit(input logic [15:0] pw, input logic [2:0] n);
        return pw[{n, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/pw_debounce.sv
// One button lane: 2-flop synchronizer, stable-level debounce, and a
// one-cycle press pulse on the debounced rising edge (releases are silent).
module pw_debounce #(
    parameter int DEBOUNCE_CYCLES = 499_999
) (
    input  logic clkin,
    input  logic reset,
    input  logic btn,
    output logic press
);
    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic          db;
    logic [CW-1:0] cnt;

    // Synchronize, count consecutive cycles the synced level disagrees, flip when the count completes.
    always_ff @(posedge clkin) begin
        if (reset) begin
            sync  <= 2'b00;
            db    <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], btn};
            press <= 1'b0;
            if (sync[1] == db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                db    <= sync[1];
                cnt   <= '0;
                press <= sync[1];
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/pw_key_entry.sv
// Password key entry: four debounced buttons -> key strobes, digit capture,
// compare against PASSWORD, unlock / fail / lockout status.
// Optional macro PW_TIMEOUT_EN adds an idle abort inside ENTRY.
module pw_key_entry
    import pw_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES = 499_999,
    parameter int          PW_LEN          = 4,
    parameter logic [15:0] PASSWORD        = 16'h00E4,
    parameter int          MAX_FAIL        = 3,
    parameter int          TIMEOUT_CYCLES  = 250_000_000
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       btn_a,
    input  logic       btn_b,
    input  logic       btn_c,
    input  logic       btn_d,
    input  logic       turnoff,
    output logic       key_a,
    output logic       key_b,
    output logic       key_c,
    output logic       key_d,
    output logic       unlock,
    output logic       fail,
    output logic       locked,
    output logic [2:0] digit_cnt
);
    // Internal digit counter is 4 bits so PW_LEN=8 is representable.
    localparam logic [3:0] PLEN = 4'(PW_LEN);
    localparam logic [2:0] MAXF = 3'(MAX_FAIL);

    logic [NUM_KEYS-1:0] btn_v, press_v, key_q;
    logic                any_press, multi_press;
    logic [1:0]          code;

    pw_state_t  state, state_n;
    logic [3:0] cnt, cnt_n;
    logic       mis, mis_n;
    logic [2:0] fcnt, fcnt_n;
    logic       fail_q, fail_n;

`ifdef PW_TIMEOUT_EN
    localparam logic [27:0] TMR_LAST = 28'(TIMEOUT_CYCLES - 1);
    logic [27:0] tmr, tmr_n;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    assign btn_v = {btn_d, btn_c, btn_b, btn_a};

    genvar g;
    generate
        for (g = 0; g < NUM_KEYS; g++) begin : g_lane
            pw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
                .clkin (clkin),
                .reset (reset),
                .btn   (btn_v[g]),
                .press (press_v[g])
            );
        end
    endgenerate

    assign any_press   = |press_v;
    assign multi_press = |(press_v & (press_v - 4'd1));

    // Encode the pressed key; with several keys the digit is forced to mismatch anyway.
    always_comb begin
        code = KEY_D;
        if (press_v[0])      code = KEY_A;
        else if (press_v[1]) code = KEY_B;
        else if (press_v[2]) code = KEY_C;
    end

    // Key strobes follow every press event except while locked out.
    always_ff @(posedge clkin) begin
        if (reset) key_q <= '0;
        else       key_q <= (state == LOCKOUT) ? '0 : press_v;
    end

    assign {key_d, key_c, key_b, key_a} = key_q;

    // State and attempt bookkeeping registers.
    always_ff @(posedge clkin) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            mis    <= 1'b0;
            fcnt   <= '0;
            fail_q <= 1'b0;
`ifdef PW_TIMEOUT_EN
            tmr    <= '0;
`endif
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            mis    <= mis_n;
            fcnt   <= fcnt_n;
            fail_q <= fail_n;
`ifdef PW_TIMEOUT_EN
            tmr    <= tmr_n;
`endif
        end
    end

    // Next state: capture digits, evaluate the cycle after the last digit, turnoff overrides all.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        mis_n   = mis;
        fcnt_n  = fcnt;
        fail_n  = 1'b0;
`ifdef PW_TIMEOUT_EN
        tmr_n   = '0;
`endif
        if (turnoff) begin
            state_n = IDLE;
            cnt_n   = '0;
            mis_n   = 1'b0;
            fcnt_n  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_press) begin
                        state_n = ENTRY;
                        cnt_n   = 4'd1;
                        mis_n   = multi_press | (code != pw_digit(PASSWORD, 3'd0));
                    end
                end
                ENTRY: begin
                    if (cnt == PLEN) begin
                        mis_n = 1'b0;
                        if (!mis) begin
                            state_n = UNLOCKED;
                            fcnt_n  = '0;
                        end else begin
                            fail_n  = 1'b1;
                            cnt_n   = '0;
                            fcnt_n  = (fcnt == MAXF) ? fcnt : fcnt + 3'd1;
                            state_n = (fcnt_n == MAXF) ? LOCKOUT : IDLE;
                        end
                    end else if (any_press) begin
                        cnt_n = cnt + 4'd1;
                        mis_n = mis | multi_press | (code != pw_digit(PASSWORD, cnt[2:0]));
                    end
`ifdef PW_TIMEOUT_EN
                    else if (tmr == TMR_LAST) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                        mis_n   = 1'b0;
                    end else begin
                        tmr_n = tmr + 28'd1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    // Status outputs decoded from state.
    always_comb begin
        unlock    = (state == UNLOCKED);
        locked    = (state == LOCKOUT);
        fail      = fail_q;
        digit_cnt = cnt[2:0];
    end

endmodule

// File: tb/tb_pw_key_entry.sv
// Directed bench for pw_key_entry with DEBOUNCE_CYCLES=4, default password a,b,c,d.
module tb_pw_key_entry;

    logic       clkin = 1'b0;
    logic       reset = 1'b1;
    logic       btn_a = 1'b0, btn_b = 1'b0, btn_c = 1'b0, btn_d = 1'b0;
    logic       turnoff = 1'b0;
    logic       key_a, key_b, key_c, key_d;
    logic       unlock, fail, locked;
    logic [2:0] digit_cnt;

    pw_key_entry #(
        .DEBOUNCE_CYCLES (4),
        .PW_LEN          (4),
        .PASSWORD        (16'h00E4),
        .MAX_FAIL        (3),
        .TIMEOUT_CYCLES  (50)
    ) dut (
        .clkin     (clkin),
        .reset     (reset),
        .btn_a     (btn_a),
        .btn_b     (btn_b),
        .btn_c     (btn_c),
        .btn_d     (btn_d),
        .turnoff   (turnoff),
        .key_a     (key_a),
        .key_b     (key_b),
        .key_c     (key_c),
        .key_d     (key_d),
        .unlock    (unlock),
        .fail      (fail),
        .locked    (locked),
        .digit_cnt (digit_cnt)
    );

    always #5 clkin = ~clkin;

    int cyc = 0;
    always @(posedge clkin) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Event log sampled on the falling edge.
    logic [3:0] keylog[$];
    int         keycyc[$];
    int         n_fail = 0;
    int         fail_cyc = -1;
    int         unlock_cyc = -1;
    logic       unlock_prev = 1'b0;

    always @(negedge clkin) begin
        if (key_a | key_b | key_c | key_d) begin
            keylog.push_back({key_d, key_c, key_b, key_a});
            keycyc.push_back(cyc);
        end
        if (fail === 1'b1) begin
            n_fail++;
            fail_cyc = cyc;
        end
        if (unlock === 1'b1 && unlock_prev !== 1'b1) unlock_cyc = cyc;
        unlock_prev = unlock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clkin);
        #1;
    endtask

    task automatic clear_log();
        keylog.delete();
        keycyc.delete();
        n_fail = 0;
        fail_cyc = -1;
        unlock_cyc = -1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(1);
        clear_log();
    endtask

    // mask bit0=a .. bit3=d
    task automatic press(input logic [3:0] mask, input int hold);
        {btn_d, btn_c, btn_b, btn_a} = mask;
        step(hold);
        {btn_d, btn_c, btn_b, btn_a} = 4'b0000;
        step(10);
    endtask

    int t0;
    int base;

    initial begin
        // Reset state
        step(2);
        chk("rst_keys", {28'd0, key_d, key_c, key_b, key_a}, 0);
        chk("rst_unlock", unlock, 0);
        chk("rst_fail", fail, 0);
        chk("rst_locked", locked, 0);
        chk("rst_digit", digit_cnt, 0);
        reset = 1'b0;
        step(1);
        clear_log();

        // Clean entry a,b,c,d
        t0 = cyc;
        press(4'b0001, 10);
        chk("latency_a", keycyc[0] - t0, 7);
        press(4'b0010, 10);
        press(4'b0100, 10);
        press(4'b1000, 10);
        chk("clean_nkeys", keylog.size(), 4);
        chk("clean_seq", {keylog[3], keylog[2], keylog[1], keylog[0]}, 16'h8421);
        chk("clean_unlock", unlock, 1);
        chk("clean_unlock_time", unlock_cyc - keycyc[3], 1);
        chk("clean_nofail", n_fail, 0);
        chk("clean_digit", digit_cnt, 4);

        // Glitch rejection (3 cycles), then 4-cycle boundary accepted
        do_reset();
        press(4'b0010, 3);
        step(5);
        chk("glitch_nkeys", keylog.size(), 0);
        chk("glitch_digit", digit_cnt, 0);
        press(4'b0010, 4);
        chk("edge4_key", keylog[0], 4'b0010);
        chk("edge4_digit", digit_cnt, 1);

        // Wrong code a,a,c,d three times -> lockout
        do_reset();
        press(4'b0001, 10); press(4'b0001, 10); press(4'b0100, 10); press(4'b1000, 10);
        chk("wrong1_nfail", n_fail, 1);
        chk("wrong1_fail_time", fail_cyc - keycyc[3], 1);
        chk("wrong1_digit", digit_cnt, 0);
        chk("wrong1_locked", locked, 0);
        for (int i = 0; i < 2; i++) begin
            press(4'b0001, 10); press(4'b0001, 10); press(4'b0100, 10); press(4'b1000, 10);
        end
        chk("wrong3_nfail", n_fail, 3);
        chk("wrong3_locked", locked, 1);
        press(4'b0001, 10);
        chk("lockout_nostrobe", keylog.size(), 12);
        chk("lockout_digit", digit_cnt, 0);
        turnoff = 1'b1;
        step(1);
        turnoff = 1'b0;
        chk("turnoff_locked", locked, 0);
        press(4'b0001, 10); press(4'b0010, 10); press(4'b0100, 10); press(4'b1000, 10);
        chk("after_turnoff_unlock", unlock, 1);

        // Simultaneous a+b, then c,d,d
        do_reset();
        press(4'b0011, 10);
        chk("simul_mask", keylog[0], 4'b0011);
        chk("simul_digit", digit_cnt, 1);
        press(4'b0100, 10); press(4'b1000, 10); press(4'b1000, 10);
        chk("simul_nfail", n_fail, 1);
        chk("simul_unlock", unlock, 0);

        // Reset mid-entry
        do_reset();
        press(4'b0001, 10); press(4'b0010, 10);
        chk("mid_digit", digit_cnt, 2);
        do_reset();
        chk("mid_digit_rst", digit_cnt, 0);
        press(4'b0001, 10); press(4'b0010, 10); press(4'b0100, 10); press(4'b1000, 10);
        chk("mid_unlock", unlock, 1);

        // turnoff on the evaluation cycle of a completing press
        do_reset();
        press(4'b0001, 10); press(4'b0010, 10); press(4'b0100, 10);
        base = n_fail;
        btn_d = 1'b1;
        step(7);
        turnoff = 1'b1;
        step(1);
        turnoff = 1'b0;
        step(3);
        btn_d = 1'b0;
        step(10);
        chk("to_win_dstrobe", keylog.size(), 4);
        chk("to_win_nofail", n_fail - base, 0);
        chk("to_win_unlock", unlock, 0);
        chk("to_win_digit", digit_cnt, 0);

`ifdef PW_TIMEOUT_EN
        // Idle timeout in ENTRY
        do_reset();
        press(4'b0001, 10);
        chk("tmo_digit_before", digit_cnt, 1);
        step(60);
        chk("tmo_digit_after", digit_cnt, 0);
        chk("tmo_nofail", n_fail, 0);
        press(4'b0001, 10); press(4'b0010, 10); press(4'b0100, 10); press(4'b1000, 10);
        chk("tmo_unlock", unlock, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
